ps2_digit_entry_ctrl: RTL and testbench
=======================================

Name: ps2_digit_entry_ctrl

Overview:
- Sequencer that consumes a PS/2 set-2 scancode byte stream and assembles a multi-digit decimal entry.
- Decodes top-row digit keys 0-9 internally, filters break and extended sequences, and supports backspace, escape and enter.
- Presents the completed BCD entry on a valid/ready output port.
- Sits between the PS/2 byte receiver and the numeric-entry consumer.

Parameters:
- NDIG, 4, maximum digits held in the entry buffer (1..8).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- in_byte  input  8  scancode byte from receiver
- in_valid  input  1  in_byte valid this cycle
- in_ready  output  1  controller can accept a byte; byte consumed when in_valid && in_ready
- out_bcd  output  4*NDIG  entry, BCD, least-significant digit (last typed) in [3:0]; unused upper nibbles are 0
- out_count  output  4  number of digits in entry (0..NDIG)
- out_ovf  output  1  at least one digit was dropped because the buffer was full
- out_valid  output  1  entry pending
- out_ready  input  1  consumer accepts entry when out_valid && out_ready

Behaviour:
- Reset: state=IDLE; buffer, out_bcd, out_count, out_ovf = 0; out_valid=0; in_ready=1. Reset has priority over every other event, including mid-sequence and while out_valid=1.
- in_ready = (state != OUT), derived from registered state only.
- out_bcd, out_count and out_ovf always reflect the live buffer; they are only meaningful to the consumer while out_valid=1.
- All effects of a byte accepted in cycle t are visible at cycle t+1.
- States: IDLE, BRK, EXT, EXTBRK, OUT.
- IDLE, byte accepted:
  - F0 -> BRK.
  - E0 -> EXT.
  - Digit code (45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9):
    - if count<NDIG: buffer = (buffer<<4) | digit, count+1.
    - else: buffer unchanged, ovf=1 (sticky).
  - 66 (backspace): if count>0, buffer>>=4 and count-1; otherwise no change. ovf unchanged.
  - 76 (escape): buffer=0, count=0, ovf=0.
  - 5A (enter): if count>0 -> OUT; else ignored.
  - Any other byte: ignored. State stays IDLE for all non-prefix bytes.
- BRK: next accepted byte is discarded -> IDLE.
- EXT, next accepted byte:
  - F0 -> EXTBRK.
  - 5A (keypad enter): same as enter above.
  - Anything else: discarded -> IDLE.
- EXTBRK: next accepted byte discarded -> IDLE.
- OUT:
  - out_valid=1; in_ready=0, so no bytes are consumed.
  - On out_ready: buffer=0, count=0, ovf=0, out_valid=0 next cycle -> IDLE.
  - Earliest next byte acceptance is the cycle after the handshake.
- Simultaneous out_ready and in_valid while in OUT: only the output handshake occurs; the byte stays pending at the receiver.
- Back-to-back bytes on consecutive cycles are supported in all non-OUT states (throughput 1 byte/cycle).
- A prefix followed by another prefix (e.g. F0 F0): in BRK the second byte is discarded like any other.

Optional Feature:
- Macro: DIGIT_ENTRY_KEYPAD_EN.
- Defined: numeric keypad codes are also decoded as digits in IDLE: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9. Their break sequences (F0 xx) are discarded as usual.
- Not defined: these codes are ignored like any other unrecognised byte.

Test Plan:
- Type 1, 2, 3 then enter: bytes 16,F0,16,1E,F0,1E,26,F0,26,5A -> out_valid=1, out_bcd=0x0123, out_count=3, out_ovf=0; out_ready pulse -> out_valid=0, count=0.
- Five digits with NDIG=4: 16,1E,26,25,2E,5A -> out_bcd=0x1234, out_count=4, out_ovf=1.
- Backspace and escape: 16,1E,66,26,5A -> out_bcd=0x0013, count 2. Then 16,76,5A -> no out_valid, count 0.
- Extended sequences: 25, E0,75, E0,F0,75, E0,5A -> out_bcd=0x0004, count 1 (E0 75 and E0 F0 75 ignored; E0 5A acts as enter). Enter with empty buffer produces no output.
- Backpressure: with entry pending, hold in_valid=1 (byte 16) and out_ready=0 for 5 cycles -> in_ready=0 and buffer unchanged. Assert out_ready -> handshake. Next cycle 16 is accepted -> count 1.
- Reset mid-sequence: 16, F0, then reset for 1 cycle -> all outputs 0, state IDLE. Then 1E,5A -> out_bcd=0x0002, count 1.

Source files
------------

// File: rtl/ps2_digit_entry_ctrl.sv
// PS/2 set-2 scancode sequencer building an NDIG-digit BCD entry; DIGIT_ENTRY_KEYPAD_EN adds keypad digits.
// Latency: effects of a byte accepted in cycle t are visible at t+1; entry is presented on out_valid.
// Backpressure: in_ready drops while an entry is pending; input resumes the cycle after out handshake.
module ps2_digit_entry_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [3:0]        out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BRK    = 3'd1,
    EXT    = 3'd2,
    EXTBRK = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_BKSP  = 8'h66;
  localparam logic [7:0] K_ESC   = 8'h76;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [3:0] NDIG_W  = 4'(NDIG);

  state_t              state_q, state_d;
  logic [4*NDIG-1:0]   entry_q, entry_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                accept;
  logic [4:0]          dig;

  // Returns {is_digit, value}
  function automatic logic [4:0] decode_digit(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    case (b)
      8'h45: r = {1'b1, 4'd0};
      8'h16: r = {1'b1, 4'd1};
      8'h1E: r = {1'b1, 4'd2};
      8'h26: r = {1'b1, 4'd3};
      8'h25: r = {1'b1, 4'd4};
      8'h2E: r = {1'b1, 4'd5};
      8'h36: r = {1'b1, 4'd6};
      8'h3D: r = {1'b1, 4'd7};
      8'h3E: r = {1'b1, 4'd8};
      8'h46: r = {1'b1, 4'd9};
`ifdef DIGIT_ENTRY_KEYPAD_EN
      8'h70: r = {1'b1, 4'd0};
      8'h69: r = {1'b1, 4'd1};
      8'h72: r = {1'b1, 4'd2};
      8'h7A: r = {1'b1, 4'd3};
      8'h6B: r = {1'b1, 4'd4};
      8'h73: r = {1'b1, 4'd5};
      8'h74: r = {1'b1, 4'd6};
      8'h6C: r = {1'b1, 4'd7};
      8'h75: r = {1'b1, 4'd8};
      8'h7D: r = {1'b1, 4'd9};
`endif
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign out_bcd   = entry_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign accept    = in_valid && in_ready;
  assign dig       = decode_digit(in_byte);

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_byte == K_BRK) begin
            state_d = BRK;
          end else if (in_byte == K_EXT) begin
            state_d = EXT;
          end else if (in_byte == K_BKSP) begin
            if (cnt_q != 4'd0) begin
              entry_d = entry_q >> 4;
              cnt_d   = cnt_q - 4'd1;
            end
          end else if (in_byte == K_ESC) begin
            entry_d = '0;
            cnt_d   = 4'd0;
            ovf_d   = 1'b0;
          end else if (in_byte == K_ENTER) begin
            if (cnt_q != 4'd0) state_d = OUT;
          end else if (dig[4]) begin
            if (cnt_q < NDIG_W) begin
              entry_d = (entry_q << 4) | {{(4*NDIG-4){1'b0}}, dig[3:0]};
              cnt_d   = cnt_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      BRK, EXTBRK: begin
        if (accept) state_d = IDLE;
      end
      EXT: begin
        if (accept) begin
          if (in_byte == K_BRK) begin
            state_d = EXTBRK;
          end else if (in_byte == K_ENTER && cnt_q != 4'd0) begin
            // keypad enter behaves exactly like main enter
            state_d = OUT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          entry_d = '0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      entry_q <= '0;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ps2_digit_entry_ctrl.sv
// Directed bench for ps2_digit_entry_ctrl (NDIG=4) with hand-computed expectations.
module tb_ps2_digit_entry_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_count;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  int errors;
  int checks;

  ps2_digit_entry_ctrl #(.NDIG(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bcd   (out_bcd),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte per cycle; waits a bounded number of cycles for in_ready.
  task automatic send(input logic [7:0] b);
    int waitc;
    waitc = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    if (!in_ready) chk("send_in_ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send(seq[i]);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_bcd",       {16'd0, out_bcd},   32'd0);
    chk("rst_count",     {28'd0, out_count}, 32'd0);
    chk("rst_ovf",       {31'd0, out_ovf},   32'd0);

    // 1,2,3 with break codes, then enter
    send_seq('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26, 8'h5A});
    chk("t1_valid",    {31'd0, out_valid}, 32'd1);
    chk("t1_bcd",      {16'd0, out_bcd},   32'h0123);
    chk("t1_count",    {28'd0, out_count}, 32'd3);
    chk("t1_ovf",      {31'd0, out_ovf},   32'd0);
    chk("t1_in_ready", {31'd0, in_ready},  32'd0);
    handshake();
    chk("t1_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_hs_count", {28'd0, out_count}, 32'd0);
    chk("t1_hs_bcd",   {16'd0, out_bcd},   32'd0);
    chk("t1_hs_rdy",   {31'd0, in_ready},  32'd1);

    // five digits into a four-digit buffer
    send_seq('{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h5A});
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_bcd",   {16'd0, out_bcd},   32'h1234);
    chk("t2_count", {28'd0, out_count}, 32'd4);
    chk("t2_ovf",   {31'd0, out_ovf},   32'd1);
    handshake();
    chk("t2_ovf_clr", {31'd0, out_ovf}, 32'd0);

    // backspace
    send_seq('{8'h16, 8'h1E, 8'h66, 8'h26, 8'h5A});
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_bcd",   {16'd0, out_bcd},   32'h0013);
    chk("t3_count", {28'd0, out_count}, 32'd2);
    handshake();
    // escape then enter on empty buffer
    send_seq('{8'h16, 8'h76, 8'h5A});
    chk("t3_esc_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_esc_count", {28'd0, out_count}, 32'd0);
    chk("t3_esc_rdy",   {31'd0, in_ready},  32'd1);
    // backspace on empty buffer, then keypad-enter on empty buffer
    send_seq('{8'h66, 8'hE0, 8'h5A});
    chk("empty_bksp_count", {28'd0, out_count}, 32'd0);
    chk("empty_kpent_valid", {31'd0, out_valid}, 32'd0);

    // break prefix twice: second F0 is swallowed, 1 is typed
    send_seq('{8'hF0, 8'hF0, 8'h16});
    chk("f0f0_count", {28'd0, out_count}, 32'd1);
    chk("f0f0_bcd",   {16'd0, out_bcd},   32'h0001);
    send(8'h76);

    // keypad digit 1
    send(8'h69);
`ifdef DIGIT_ENTRY_KEYPAD_EN
    chk("kp_count", {28'd0, out_count}, 32'd1);
`else
    chk("kp_count", {28'd0, out_count}, 32'd0);
`endif
    send(8'h76);

    // extended sequences
    send_seq('{8'h25, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h5A});
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_bcd",   {16'd0, out_bcd},   32'h0004);
    chk("t4_count", {28'd0, out_count}, 32'd1);

    // backpressure with entry pending
    in_byte  = 8'h16;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    chk("bp_count", {28'd0, out_count}, 32'd1);
    chk("bp_bcd",   {16'd0, out_bcd},   32'h0004);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_count", {28'd0, out_count}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_next_count", {28'd0, out_count}, 32'd1);
    chk("bp_next_bcd",   {16'd0, out_bcd},   32'h0001);
    send(8'h76);

    // reset mid-sequence (state BRK, one digit held)
    send_seq('{8'h16, 8'hF0});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_count", {28'd0, out_count}, 32'd0);
    chk("mr_bcd",   {16'd0, out_bcd},   32'd0);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_rdy",   {31'd0, in_ready},  32'd1);
    send_seq('{8'h1E, 8'h5A});
    chk("mr_t_valid", {31'd0, out_valid}, 32'd1);
    chk("mr_t_bcd",   {16'd0, out_bcd},   32'h0002);
    chk("mr_t_count", {28'd0, out_count}, 32'd1);

    // reset while an entry is pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ro_valid", {31'd0, out_valid}, 32'd0);
    chk("ro_count", {28'd0, out_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
